mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles without dmem_ack_i before the access is aborted.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port RegWrite_i  in  1  EX/MEM register-write flag.
REQ-005 SHALL have port MemtoReg_i  in  1  EX/MEM writeback-select flag.
REQ-006 SHALL have port Branch_i  in  1  EX/MEM branch flag.
REQ-007 SHALL have port MemRead_i  in  1  EX/MEM load flag.
REQ-008 SHALL have port MemWrite_i  in  1  EX/MEM store flag.
REQ-009 SHALL have port PCadd_sum_i  in  32  branch target.
REQ-010 SHALL have port ALU_zero_i  in  1  branch condition.
REQ-011 SHALL have port ALU_result_i  in  32  memory address or ALU result.
REQ-012 SHALL have port RTdata_i  in  32  store data.
REQ-013 SHALL have port RDdata_i  in  5  destination register.
REQ-014 SHALL have port dmem_req_o  out  1  data-memory request.
REQ-015 SHALL have port dmem_we_o  out  1  1 = write, 0 = read.
REQ-016 SHALL have port dmem_addr_o  out  32  word address.
REQ-017 SHALL have port dmem_wdata_o  out  32  write data.
REQ-018 SHALL have port dmem_ack_i  in  1  access complete.
REQ-019 SHALL have port dmem_rdata_i  in  32  read data, valid while dmem_ack_i = 1.
REQ-020 SHALL have port stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-021 SHALL have port PCSrc_o  out  1  taken branch; also flushes younger stages.
REQ-022 SHALL have port branch_target_o  out  32  equals PCadd_sum_i.
REQ-023 SHALL have ports RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control.
REQ-024 SHALL have ports ReadData_o, ALU_result_o  out  32 each  MEM/WB data.
REQ-025 SHALL have port RDdata_o  out  5  MEM/WB destination register.
REQ-026 SHALL have port err_o  out  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-027 SHALL implement an FSM with two states, IDLE and ACCESS.
REQ-028 SHALL define memop = MemRead_i | MemWrite_i, and misaligned = memop & (ALU_result_i[1:0] != 0).
REQ-029 IDLE, aligned memop: SHALL assert stall_o combinationally, latch address, write data, control and RDdata_i, and move to ACCESS.
REQ-030 ACCESS: SHALL hold dmem_req_o = 1 with dmem_we_o, dmem_addr_o and dmem_wdata_o stable; in IDLE, dmem_req_o SHALL be 0.
REQ-031 ACCESS, dmem_ack_i = 1: SHALL deassert stall_o in that cycle, load MEM/WB with dmem_rdata_i (load) or 0 (store) at the edge, and return to IDLE; minimum memop latency is 2 cycles.
REQ-032 Non-memop in IDLE: SHALL load MEM/WB from the inputs at the next edge (1-cycle latency) with stall_o = 0.
REQ-033 While stall_o = 1, MEM/WB SHALL capture a bubble: RegWrite_o = 0, MemtoReg_o = 0.
REQ-034 Misaligned: SHALL issue no request, keep stall_o = 0, pulse err_o, and load MEM/WB with RegWrite_o = 0.
REQ-035 Timeout: SHALL count ACCESS cycles with dmem_ack_i = 0; when the count reaches TIMEOUT it SHALL drop dmem_req_o, pulse err_o, squash writeback, release stall_o and return to IDLE.
REQ-036 dmem_ack_i SHALL be ignored in IDLE.
REQ-037 SHALL drive PCSrc_o = Branch_i & ALU_zero_i & ~stall_o combinationally; branch_target_o = PCadd_sum_i.
REQ-038 If a branch and a memop are both present, the memop SHALL complete first and PCSrc_o SHALL assert in the non-stalled cycle.

Reset
REQ-039 With rst_i = 1 at an edge: state SHALL become IDLE, the counter 0, and every registered output 0, including mid-ACCESS, where dmem_req_o drops at that edge.
REQ-040 During rst_i, stall_o and PCSrc_o SHALL be 0.

Structure
REQ-041 Package mem_stage_pkg SHALL hold the state enum, the default TIMEOUT, and the width constants 32 and 5.
REQ-042 The timeout counter SHALL be the sub-module mem_timeout_cnt (clear, enable, expired).

Verification
REQ-043 Stimulus: ALU op, RegWrite_i = 1, ALU_result_i = 0x10, RDdata_i = 3. Required response: next edge ALU_result_o = 0x10, RDdata_o = 3, stall_o never 1.
REQ-044 Stimulus: load at 0x40, ack 3 cycles after the request with rdata 0xDEADBEEF. Required response: stall_o high 4 cycles, ReadData_o = 0xDEADBEEF, RegWrite_o = 1 exactly once.
REQ-045 Stimulus: store at 0x44 with RTdata_i = 0x55, ack on the first ACCESS cycle. Required response: dmem_we_o = 1, dmem_wdata_o = 0x55, 2-cycle latency.
REQ-046 Stimulus: load at 0x42. Required response: no dmem_req_o, one err_o pulse, RegWrite_o = 0.
REQ-047 Stimulus: no ack for 16 cycles. Required response: abort, one err_o pulse, stall_o released; and rst_i mid-ACCESS forces all outputs to 0 at the next edge.
REQ-048 Stimulus: Branch_i = 1, ALU_zero_i = 1, PCadd_sum_i = 0x100. Required response: PCSrc_o = 1, branch_target_o = 0x100 in the same cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage controller.
package mem_stage_pkg;

  localparam int XLEN            = 32;
  localparam int REG_AW          = 5;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts stalled ACCESS cycles; expired flags the cycle that would reach LIMIT.
module mem_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Asserted during the LIMIT-th unacknowledged cycle so the abort lands on that edge.
  assign expired = enable && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives a handshaked data memory, stalls the pipeline
// during accesses, resolves branches and produces the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [XLEN-1:0]   PCadd_sum_i,
  input  logic              ALU_zero_i,
  input  logic [XLEN-1:0]   ALU_result_i,
  input  logic [XLEN-1:0]   RTdata_i,
  input  logic [REG_AW-1:0] RDdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_o,
  output logic              PCSrc_o,
  output logic [XLEN-1:0]   branch_target_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [XLEN-1:0]   ReadData_o,
  output logic [XLEN-1:0]   ALU_result_o,
  output logic [REG_AW-1:0] RDdata_o,
  output logic              err_o
);

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic              regwrite_reg;
  logic              memtoreg_reg;
  logic [REG_AW-1:0] rd_reg;

  logic memop, misaligned, expired;
  logic stall, start, complete, abort;

  assign memop      = MemRead_i | MemWrite_i;
  assign misaligned = memop && (ALU_result_i[1:0] != 2'b00);

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state_reg == IDLE),
    .enable  ((state_reg == ACCESS) && !dmem_ack_i),
    .expired (expired)
  );

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop && !misaligned) begin
          stall      = 1'b1;
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle still completes the access.
        if (dmem_ack_i) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
    endcase
    if (rst_i) begin
      state_next = IDLE;
      stall      = 1'b0;
      start      = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      rd_reg       <= '0;
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      ReadData_o   <= '0;
      ALU_result_o <= '0;
      RDdata_o     <= '0;
      err_o        <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_o     <= 1'b0;
      if (start) begin
        we_reg       <= MemWrite_i;
        addr_reg     <= ALU_result_i;
        wdata_reg    <= RTdata_i;
        regwrite_reg <= RegWrite_i;
        memtoreg_reg <= MemtoReg_i;
        rd_reg       <= RDdata_i;
      end
      if (complete) begin
        RegWrite_o   <= regwrite_reg;
        MemtoReg_o   <= memtoreg_reg;
        ReadData_o   <= we_reg ? '0 : dmem_rdata_i;
        ALU_result_o <= addr_reg;
        RDdata_o     <= rd_reg;
      end else if (stall || abort) begin
        // Bubble into MEM/WB; data fields are don't-care while RegWrite_o is low.
        RegWrite_o <= 1'b0;
        MemtoReg_o <= 1'b0;
        err_o      <= abort;
      end else if (state_reg == IDLE) begin
        RegWrite_o   <= RegWrite_i && !misaligned;
        MemtoReg_o   <= MemtoReg_i && !misaligned;
        ReadData_o   <= '0;
        ALU_result_o <= ALU_result_i;
        RDdata_o     <= RDdata_i;
        err_o        <= misaligned;
      end
    end
  end

  assign dmem_req_o      = (state_reg == ACCESS);
  assign dmem_we_o       = we_reg;
  assign dmem_addr_o     = addr_reg;
  assign dmem_wdata_o    = wdata_reg;
  assign stall_o         = stall;
  assign PCSrc_o         = Branch_i && ALU_zero_i && !stall && !rst_i;
  assign branch_target_o = PCadd_sum_i;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with hand-computed expectations.
module tb_mem_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i;
  logic [31:0] PCadd_sum_i;
  logic        ALU_zero_i;
  logic [31:0] ALU_result_i, RTdata_i;
  logic [4:0]  RDdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, PCSrc_o;
  logic [31:0] branch_target_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALU_result_o;
  logic [4:0]  RDdata_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mem_stage_ctrl #(.TIMEOUT(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .RegWrite_i      (RegWrite_i),
    .MemtoReg_i      (MemtoReg_i),
    .Branch_i        (Branch_i),
    .MemRead_i       (MemRead_i),
    .MemWrite_i      (MemWrite_i),
    .PCadd_sum_i     (PCadd_sum_i),
    .ALU_zero_i      (ALU_zero_i),
    .ALU_result_i    (ALU_result_i),
    .RTdata_i        (RTdata_i),
    .RDdata_i        (RDdata_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_ack_i      (dmem_ack_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .stall_o         (stall_o),
    .PCSrc_o         (PCSrc_o),
    .branch_target_o (branch_target_o),
    .RegWrite_o      (RegWrite_o),
    .MemtoReg_o      (MemtoReg_o),
    .ReadData_o      (ReadData_o),
    .ALU_result_o    (ALU_result_o),
    .RDdata_o        (RDdata_o),
    .err_o           (err_o)
  );

  task automatic clear_inputs();
    RegWrite_i = 0; MemtoReg_i = 0; Branch_i = 0; MemRead_i = 0; MemWrite_i = 0;
    PCadd_sum_i = 0; ALU_zero_i = 0; ALU_result_i = 0; RTdata_i = 0; RDdata_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1;
    clear_inputs();
    step();
    step();
    MemRead_i = 1; ALU_result_i = 32'h40; Branch_i = 1; ALU_zero_i = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    n_cmp++; if (PCSrc_o !== 1'b0) begin n_bad++; $display("FAIL reset_pcsrc got=%b want=0", PCSrc_o); end
    step();
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", dmem_req_o); end
    n_cmp++; if (RegWrite_o !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite got=%b want=0", RegWrite_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_o); end
    n_cmp++; if (ReadData_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", ReadData_o); end
    clear_inputs();
    rst_i = 0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_alu_op();
    RegWrite_i = 1; ALU_result_i = 32'h10; RDdata_i = 5'd3;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_stall got=%b want=0", stall_o); end
    step();
    n_cmp++; if (ALU_result_o !== 32'h10) begin n_bad++; $display("FAIL alu_result got=%h want=10", ALU_result_o); end
    n_cmp++; if (RDdata_o !== 5'd3) begin n_bad++; $display("FAIL alu_rd got=%0d want=3", RDdata_o); end
    n_cmp++; if (RegWrite_o !== 1'b1) begin n_bad++; $display("FAIL alu_regwrite got=%b want=1", RegWrite_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_stall2 got=%b want=0", stall_o); end
    clear_inputs();
    $display("test_alu_op done");
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    int wr_cnt = 0;
    MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1; ALU_result_i = 32'h40; RDdata_i = 5'd5;
    for (int c = 0; c < 5; c++) begin
      dmem_ack_i   = (c == 4);
      dmem_rdata_i = (c == 4) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (stall_o) stall_cnt++;
      if (c == 1) begin
        n_cmp++; if (dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL load_req got=%b want=1", dmem_req_o); end
        n_cmp++; if (dmem_addr_o !== 32'h40) begin n_bad++; $display("FAIL load_addr got=%h want=40", dmem_addr_o); end
        n_cmp++; if (dmem_we_o !== 1'b0) begin n_bad++; $display("FAIL load_we got=%b want=0", dmem_we_o); end
      end
      step();
      if (RegWrite_o) wr_cnt++;
    end
    clear_inputs();
    n_cmp++; if (ReadData_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata got=%h want=deadbeef", ReadData_o); end
    n_cmp++; if (MemtoReg_o !== 1'b1) begin n_bad++; $display("FAIL load_memtoreg got=%b want=1", MemtoReg_o); end
    n_cmp++; if (RDdata_o !== 5'd5) begin n_bad++; $display("FAIL load_rd got=%0d want=5", RDdata_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL load_req_after got=%b want=0", dmem_req_o); end
    for (int c = 0; c < 2; c++) begin
      step();
      if (RegWrite_o) wr_cnt++;
    end
    n_cmp++; if (stall_cnt != 4) begin n_bad++; $display("FAIL load_stall_cycles got=%0d want=4", stall_cnt); end
    n_cmp++; if (wr_cnt != 1) begin n_bad++; $display("FAIL load_regwrite_count got=%0d want=1", wr_cnt); end
    $display("test_load done");
  endtask

  task automatic test_store();
    MemWrite_i = 1; ALU_result_i = 32'h44; RTdata_i = 32'h55; RDdata_i = 5'd7;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL store_stall0 got=%b want=1", stall_o); end
    step();
    dmem_ack_i = 1; dmem_rdata_i = 32'h1234;
    #1;
    n_cmp++; if (dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL store_req got=%b want=1", dmem_req_o); end
    n_cmp++; if (dmem_we_o !== 1'b1) begin n_bad++; $display("FAIL store_we got=%b want=1", dmem_we_o); end
    n_cmp++; if (dmem_wdata_o !== 32'h55) begin n_bad++; $display("FAIL store_wdata got=%h want=55", dmem_wdata_o); end
    n_cmp++; if (dmem_addr_o !== 32'h44) begin n_bad++; $display("FAIL store_addr got=%h want=44", dmem_addr_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL store_stall1 got=%b want=0", stall_o); end
    step();
    clear_inputs();
    n_cmp++; if (ReadData_o !== 32'h0) begin n_bad++; $display("FAIL store_rdata got=%h want=0", ReadData_o); end
    n_cmp++; if (ALU_result_o !== 32'h44) begin n_bad++; $display("FAIL store_alu got=%h want=44", ALU_result_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL store_req_after got=%b want=0", dmem_req_o); end
    step();
    $display("test_store done");
  endtask

  task automatic test_misaligned();
    MemRead_i = 1; RegWrite_i = 1; ALU_result_i = 32'h42; RDdata_i = 5'd9;
    dmem_ack_i = 1; dmem_rdata_i = 32'hCAFE0000;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL mis_stall got=%b want=0", stall_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL mis_req got=%b want=0", dmem_req_o); end
    step();
    clear_inputs();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL mis_err got=%b want=1", err_o); end
    n_cmp++; if (RegWrite_o !== 1'b0) begin n_bad++; $display("FAIL mis_regwrite got=%b want=0", RegWrite_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL mis_req2 got=%b want=0", dmem_req_o); end
    step();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mis_err_pulse got=%b want=0", err_o); end
    $display("test_misaligned done");
  endtask

  task automatic test_timeout();
    int stall_cnt = 0;
    int req_cnt = 0;
    bit done = 0;
    MemRead_i = 1; RegWrite_i = 1; ALU_result_i = 32'h80; RDdata_i = 5'd4;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall_o) stall_cnt++;
      if (dmem_req_o) req_cnt++;
      if (!stall_o) begin
        clear_inputs();
        done = 1;
      end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL to_release got=%b want=1", done); end
    n_cmp++; if (stall_cnt != 16) begin n_bad++; $display("FAIL to_stall_cycles got=%0d want=16", stall_cnt); end
    n_cmp++; if (req_cnt != 16) begin n_bad++; $display("FAIL to_req_cycles got=%0d want=16", req_cnt); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL to_err got=%b want=1", err_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL to_req_drop got=%b want=0", dmem_req_o); end
    n_cmp++; if (RegWrite_o !== 1'b0) begin n_bad++; $display("FAIL to_regwrite got=%b want=0", RegWrite_o); end
    step();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse got=%b want=0", err_o); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_access();
    MemWrite_i = 1; ALU_result_i = 32'h48; RTdata_i = 32'h77; RDdata_i = 5'd2;
    step();
    step();
    #1;
    n_cmp++; if (dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL rma_req_before got=%b want=1", dmem_req_o); end
    rst_i = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rma_stall got=%b want=0", stall_o); end
    step();
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL rma_req got=%b want=0", dmem_req_o); end
    n_cmp++; if (dmem_we_o !== 1'b0) begin n_bad++; $display("FAIL rma_we got=%b want=0", dmem_we_o); end
    n_cmp++; if (dmem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rma_addr got=%h want=0", dmem_addr_o); end
    n_cmp++; if (dmem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL rma_wdata got=%h want=0", dmem_wdata_o); end
    n_cmp++; if (ALU_result_o !== 32'h0) begin n_bad++; $display("FAIL rma_alu got=%h want=0", ALU_result_o); end
    n_cmp++; if (RDdata_o !== 5'd0) begin n_bad++; $display("FAIL rma_rd got=%0d want=0", RDdata_o); end
    clear_inputs();
    rst_i = 0;
    step();
    $display("test_reset_mid_access done");
  endtask

  task automatic test_branch();
    Branch_i = 1; ALU_zero_i = 1; PCadd_sum_i = 32'h100;
    #1;
    n_cmp++; if (PCSrc_o !== 1'b1) begin n_bad++; $display("FAIL br_pcsrc got=%b want=1", PCSrc_o); end
    n_cmp++; if (branch_target_o !== 32'h100) begin n_bad++; $display("FAIL br_target got=%h want=100", branch_target_o); end
    ALU_zero_i = 0;
    #1;
    n_cmp++; if (PCSrc_o !== 1'b0) begin n_bad++; $display("FAIL br_not_taken got=%b want=0", PCSrc_o); end
    step();
    clear_inputs();
    $display("test_branch done");
  endtask

  task automatic test_branch_with_memop();
    Branch_i = 1; ALU_zero_i = 1; PCadd_sum_i = 32'h200;
    MemRead_i = 1; ALU_result_i = 32'h48;
    #1;
    n_cmp++; if (PCSrc_o !== 1'b0) begin n_bad++; $display("FAIL brm_pcsrc0 got=%b want=0", PCSrc_o); end
    step();
    #1;
    n_cmp++; if (PCSrc_o !== 1'b0) begin n_bad++; $display("FAIL brm_pcsrc1 got=%b want=0", PCSrc_o); end
    step();
    dmem_ack_i = 1; dmem_rdata_i = 32'h600D;
    #1;
    n_cmp++; if (PCSrc_o !== 1'b1) begin n_bad++; $display("FAIL brm_pcsrc2 got=%b want=1", PCSrc_o); end
    n_cmp++; if (branch_target_o !== 32'h200) begin n_bad++; $display("FAIL brm_target got=%h want=200", branch_target_o); end
    step();
    clear_inputs();
    n_cmp++; if (ReadData_o !== 32'h600D) begin n_bad++; $display("FAIL brm_rdata got=%h want=600d", ReadData_o); end
    step();
    $display("test_branch_with_memop done");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_branch();
    test_branch_with_memop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
